// File: rtl/ring_bench_pkg.sv
// Shared types and default sizes for the ring benchmark monitors.
package ring_bench_pkg;

  // Measurement sequencer states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2,
    HOLD    = 2'd3
  } mon_state_t;

  localparam int unsigned DEF_SYNC_STAGES = 2;
  localparam int unsigned DEF_WIN_W       = 16;
  localparam int unsigned DEF_CNT_W       = 16;
  localparam int unsigned DEF_STALL_W     = 8;

endpackage : ring_bench_pkg

// File: rtl/tap_sync.sv
// Brings one asynchronous ring node into the clk domain and flags its edges.
// rise/any_edge compare the synchronized level with the previous one.
module tap_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tap_i,
  output logic tap_s_o,
  output logic rise_o,
  output logic any_edge_o
);

  (* async_reg = "true" *) logic [SYNC_STAGES-1:0] sync_q;
  logic prev_q;

  // Synchronizer chain plus one history flop for edge detection.
  // NOTE: every flop here uses <= so all stages shift on the same edge;
  // blocking assignments would collapse the chain into a single stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], tap_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign tap_s_o    = sync_q[SYNC_STAGES-1];
  assign rise_o     = tap_s_o & ~prev_q;
  assign any_edge_o = tap_s_o ^ prev_q;

endmodule : tap_sync

// File: rtl/ring_osc_monitor.sv
// Counts rising edges of a free-running ring tap over a programmable window
// of clk cycles, returns the count over a valid/ready handshake, and flags
// a ring that has stopped toggling.
module ring_osc_monitor
  import ring_bench_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int unsigned WIN_W       = DEF_WIN_W,
  parameter int unsigned CNT_W       = DEF_CNT_W,
  parameter int unsigned STALL_W     = DEF_STALL_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ring_tap,
  input  logic             start,
  input  logic [WIN_W-1:0] win_len,
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [CNT_W-1:0] res_count,
  output logic             res_sat,
  output logic             stall
);

  mon_state_t           state_q, state_d;
  logic [WIN_W-1:0]     win_cnt_q, win_cnt_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 sat_q, sat_d;
  logic [STALL_W-1:0]   stall_tmr_q, stall_tmr_d;

  logic tap_s;
  logic rise;
  logic any_edge;

  tap_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_tap_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .tap_i     (ring_tap),
    .tap_s_o   (tap_s),
    .rise_o    (rise),
    .any_edge_o(any_edge)
  );

  // Sequencer: arm on a valid start, count for win_len cycles, hold result.
  // NOTE: every variable gets its current value first so no path through
  // the case leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    win_cnt_d = win_cnt_q;
    count_d   = count_q;
    sat_d     = sat_q;
    case (state_q)
      IDLE: begin
        if (start && (win_len != '0)) begin
          state_d   = ARM;
          win_cnt_d = win_len;
          count_d   = '0;
          sat_d     = 1'b0;
        end
      end
      // One settling cycle so a level left over from before start is not
      // mistaken for a rise.
      ARM: state_d = MEASURE;
      MEASURE: begin
        if (rise) begin
          if (count_q == '1) sat_d = 1'b1;
          else               count_d = count_q + CNT_W'(1);
        end
        win_cnt_d = win_cnt_q - WIN_W'(1);
        if (win_cnt_q == WIN_W'(1)) state_d = HOLD;
      end
      HOLD: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Stall timer: restarts on any synchronized edge, otherwise saturates.
  always_comb begin
    stall_tmr_d = stall_tmr_q;
    if (any_edge)                stall_tmr_d = '0;
    else if (stall_tmr_q != '1)  stall_tmr_d = stall_tmr_q + STALL_W'(1);
  end

  // State registers; reset discards any partial measurement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      win_cnt_q   <= '0;
      count_q     <= '0;
      sat_q       <= 1'b0;
      stall_tmr_q <= '0;
    end else begin
      state_q     <= state_d;
      win_cnt_q   <= win_cnt_d;
      count_q     <= count_d;
      sat_q       <= sat_d;
      stall_tmr_q <= stall_tmr_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign res_valid = (state_q == HOLD);
  assign res_count = count_q;
  assign res_sat   = sat_q;
  assign stall     = (stall_tmr_q == '1);

endmodule : ring_osc_monitor

// File: tb/tb_ring_osc_monitor.sv
// Bench for ring_osc_monitor: a default instance and a narrow one
// (CNT_W=4, STALL_W=4) share all inputs. Expected counts and stall flags
// come from a recorded history of sampled tap values: a rise consumed at
// clock edge m is hist[m-SYNC]=1 with hist[m-SYNC-1]=0, and a window
// accepted at edge a counts edges a+2 .. a+1+win_len.
module tb_ring_osc_monitor;

  localparam int SYNC    = 2;
  localparam int CNT_B   = 4;
  localparam int STALL_A = 8;
  localparam int STALL_B = 4;
  localparam int MAX_A   = 65535;
  localparam int MAX_B   = (1 << CNT_B) - 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ring_tap = 1'b0;
  logic        start = 1'b0;
  logic        res_ready = 1'b0;
  logic [15:0] win_len = '0;

  logic        busy_a, res_valid_a, res_sat_a, stall_a;
  logic [15:0] res_count_a;
  logic        busy_b, res_valid_b, res_sat_b, stall_b;
  logic [3:0]  res_count_b;

  int errors = 0;
  int checks = 0;
  int n = 0;          // index of the most recent rising clk edge
  int last_rst = 0;   // last edge seen with rst_n low
  bit hist [0:16383];

  int tap_mode = 0;   // 0 hold, 1 square wave, 2 random
  int hold_val = 0;
  int half_per = 4;
  int phase = 0;

  ring_osc_monitor dut_a (
    .clk(clk), .rst_n(rst_n), .ring_tap(ring_tap), .start(start),
    .win_len(win_len), .busy(busy_a), .res_valid(res_valid_a),
    .res_ready(res_ready), .res_count(res_count_a), .res_sat(res_sat_a),
    .stall(stall_a)
  );

  ring_osc_monitor #(.SYNC_STAGES(SYNC), .WIN_W(16), .CNT_W(CNT_B),
                     .STALL_W(STALL_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .ring_tap(ring_tap), .start(start),
    .win_len(win_len), .busy(busy_b), .res_valid(res_valid_b),
    .res_ready(res_ready), .res_count(res_count_b), .res_sat(res_sat_b),
    .stall(stall_b)
  );

  initial forever #5 clk = ~clk;

  // Record what the synchronizer samples; reset makes the whole chain look low.
  initial forever begin
    @(posedge clk);
    n = n + 1;
    hist[n] = rst_n ? ring_tap : 1'b0;
    if (!rst_n) begin
      last_rst = n;
      for (int s = 0; s <= SYNC; s++) if (n - s >= 0) hist[n-s] = 1'b0;
    end
  end

  // Tap generator, changes away from the sampling edge.
  initial forever begin
    @(negedge clk);
    phase = phase + 1;
    case (tap_mode)
      0:       ring_tap = hold_val[0];
      1:       ring_tap = ((phase / half_per) % 2) == 1;
      default: ring_tap = 1'($urandom % 2);
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int rises(input int a, input int w);
    int c = 0;
    for (int m = a + 2; m <= a + 1 + w; m++)
      if (hist[m-SYNC] && !hist[m-SYNC-1]) c++;
    return c;
  endfunction

  // Consecutive edges since reset with no synchronized level change.
  function automatic bit stall_exp(input int width);
    int k = 0;
    for (int m = n; m > last_rst; m--) begin
      if (hist[m-SYNC] != hist[m-SYNC-1]) break;
      k++;
    end
    return k >= ((1 << width) - 1);
  endfunction

  task automatic check_stall(input string tag);
    check({tag, ":stall_a"}, stall_a, stall_exp(STALL_A));
    check({tag, ":stall_b"}, stall_b, stall_exp(STALL_B));
  endtask

  // One measurement from start to handshake, compared with the history model.
  task automatic do_measure(input int w, input int ready_dly, input bit poke,
                            input string tag, input int exp_a, input int exp_b,
                            input int exp_sat_b);
    int a, e, ea, eb;
    bit got;
    @(negedge clk);
    start = 1'b1;
    win_len = 16'(w);
    @(negedge clk);
    start = 1'b0;
    a = n;
    check({tag, ":busy_a"}, busy_a, 1);
    check({tag, ":busy_b"}, busy_b, 1);
    got = 1'b0;
    for (int i = 0; i < w + 8 && !got; i++) begin
      @(negedge clk);
      got = res_valid_a;
    end
    check({tag, ":valid_seen"}, got, 1);
    check({tag, ":window_len"}, n, a + 1 + w);
    e  = rises(a, w);
    ea = (e > MAX_A) ? MAX_A : e;
    eb = (e > MAX_B) ? MAX_B : e;
    check({tag, ":valid_b"}, res_valid_b, 1);
    check({tag, ":count_a"}, res_count_a, ea);
    check({tag, ":sat_a"}, res_sat_a, e > MAX_A);
    check({tag, ":count_b"}, res_count_b, eb);
    check({tag, ":sat_b"}, res_sat_b, e > MAX_B);
    if (exp_a >= 0)     check({tag, ":count_a_fixed"}, res_count_a, exp_a);
    if (exp_b >= 0)     check({tag, ":count_b_fixed"}, res_count_b, exp_b);
    if (exp_sat_b >= 0) check({tag, ":sat_b_fixed"}, res_sat_b, exp_sat_b);
    check_stall(tag);
    for (int i = 0; i < ready_dly; i++) begin
      if (poke) begin
        start = (i == 2);
        win_len = 16'd10;
      end
      @(negedge clk);
      check({tag, ":hold_valid"}, res_valid_a, 1);
      check({tag, ":hold_count"}, res_count_a, ea);
    end
    start = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check({tag, ":done_valid"}, res_valid_a, 0);
    check({tag, ":done_busy_a"}, busy_a, 0);
    check({tag, ":done_busy_b"}, busy_b, 0);
    @(negedge clk);
    check({tag, ":idle_busy"}, busy_a, 0);
    check({tag, ":idle_count"}, res_count_a, ea);
  endtask

  initial begin
    int a;
    // Reset state.
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst:busy", busy_a, 0);
    check("rst:valid", res_valid_a, 0);
    check("rst:count", res_count_a, 0);
    check("rst:sat", res_sat_a, 0);
    check("rst:stall", stall_a, 0);
    rst_n = 1'b1;

    // Stall: tap held low, narrow timer trips after 15 quiet cycles.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_stall("stall_ramp");
    end
    check("stall_b_set", stall_b, 1);
    check("stall_a_clear", stall_a, 0);
    @(posedge clk);
    #1 hold_val = 1;
    @(negedge clk);
    for (int i = 0; i < SYNC + 1; i++) begin
      @(negedge clk);
      check_stall("stall_release");
    end
    check("stall_b_cleared", stall_b, 0);

    // Square wave of period 8, window 64.
    tap_mode = 1;
    half_per = 4;
    repeat (4) @(negedge clk);
    do_measure(64, 0, 1'b0, "t1", 8, 8, 0);

    // Toggle every cycle: 32 rises saturates the narrow counter.
    half_per = 1;
    repeat (4) @(negedge clk);
    do_measure(64, 0, 1'b0, "t2", 32, 15, 1);

    // Result held under backpressure, start during HOLD is dropped.
    tap_mode = 2;
    do_measure(40, 5, 1'b1, "t3", -1, -1, -1);

    // Reset in the middle of a measurement.
    tap_mode = 1;
    half_per = 2;
    repeat (4) @(negedge clk);
    @(negedge clk);
    start = 1'b1;
    win_len = 16'd100;
    @(negedge clk);
    start = 1'b0;
    a = n;
    repeat (14) @(negedge clk);
    check("t5:partial", res_count_a, rises(a, n - a - 1));
    rst_n = 1'b0;
    #1;
    check("t5:busy", busy_a, 0);
    check("t5:valid", res_valid_a, 0);
    check("t5:count", res_count_a, 0);
    check("t5:count_b", res_count_b, 0);
    check("t5:sat", res_sat_a, 0);
    check("t5:stall", stall_b, 0);
    @(negedge clk);
    rst_n = 1'b1;
    do_measure(16, 1, 1'b0, "t5b", 4, 4, 0);

    // Zero-length window is ignored; length one gives a one-cycle window.
    @(negedge clk);
    start = 1'b1;
    win_len = 16'd0;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("t6:busy_zero", busy_a, 0);
      check("t6:valid_zero", res_valid_a, 0);
      @(negedge clk);
    end
    do_measure(1, 0, 1'b0, "t6", -1, -1, -1);

    // Randomized windows and tap patterns.
    for (int r = 0; r < 8; r++) begin
      tap_mode = int'($urandom_range(0, 2));
      hold_val = int'($urandom % 2);
      half_per = int'($urandom_range(1, 5));
      repeat (3) @(negedge clk);
      do_measure(int'($urandom_range(1, 120)), int'($urandom_range(0, 4)),
                 1'b0, "rnd", -1, -1, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_ring_osc_monitor
